// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, FSM state type and RISC-V ABI register indices for the register file
package reg_file_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int ZERO = 0,  RA = 1,  SP = 2,  GP = 3,  TP = 4,  T0 = 5,  T1 = 6,  T2 = 7;
  localparam int S0 = 8,    S1 = 9,  A0 = 10, A1 = 11, A2 = 12, A3 = 13, A4 = 14, A5 = 15;
  localparam int A6 = 16,   A7 = 17, S2 = 18, S3 = 19, S4 = 20, S5 = 21, S6 = 22, S7 = 23;
  localparam int S8 = 24,   S9 = 25, S10 = 26, S11 = 27, T3 = 28, T4 = 29, T5 = 30, T6 = 31;
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits with one set port, one clear port and a sync flush.
//   clk: clock; flush: synchronous clear of all bits
//   set_en/set_addr: mark a register busy; clr_en/clr_addr: mark a register ready (set wins on a tie)
//   addr: NRD packed lookup addresses; busy: lookup result per port
module reg_file_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] addr,
  output logic [NRD-1:0]    busy
);
  logic [NREGS-1:0] bits;
  always_ff @(posedge clk) begin
    if (flush) bits <= '0;
    else begin
      if (clr_en) bits[clr_addr] <= 1'b0;
      if (set_en) bits[set_addr] <= 1'b1;
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_lk
    assign busy[i] = bits[addr[i*AW +: AW]];
  end
endmodule

// File: rtl/reg_file_scb.sv
// reg_file_scb: register file with NRD combinational read ports, one write port, write bypass,
// busy scoreboard and a post-reset clearing sweep (one entry per cycle, RAM friendly).
//   clk, rst_n (sync active-low); rd_addr/rd_data/rd_busy: packed per-port reads
//   wr_en/wr_addr/wr_data: writeback; iss_en/iss_addr: issue marks destination busy
//   init_done: high once the clearing sweep has finished
module reg_file_scb import reg_file_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                init_done
);
  localparam int N2 = 2**AW;
  localparam logic [N2-1:0] ONE = N2'(1);
  // addresses that map to real, writable storage: in range and not a hardwired x0
  localparam logic [N2-1:0] VMASK = ((ONE << NREGS) - ONE) & ~((ZERO_REG != 0) ? ONE : '0);
  state_t          state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] rf [NREGS];
  logic            clr, run, wr_ok, iss_ok, we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic [NRD-1:0]  lk;
  assign clr       = state == CLEAR;
  assign run       = state == RUN;
  assign init_done = run;
  assign wr_ok     = run & wr_en & VMASK[wr_addr];
  assign iss_ok    = run & iss_en & VMASK[iss_addr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (clr) begin
      ptr <= ptr + AW'(1);
      if (ptr == AW'(NREGS-1)) state <= RUN;
    end
  end
  // the sweep and writeback share a single write port so the array stays a plain RAM
  assign we = rst_n & (clr | wr_ok);
  assign wa = clr ? ptr : wr_addr;
  assign wd = clr ? '0 : wr_data;
  always_ff @(posedge clk) if (we) rf[wa] <= wd;
  reg_file_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_scb (
    .clk(clk), .flush(~rst_n),
    .set_en(iss_ok), .set_addr(iss_addr),
    .clr_en(wr_ok), .clr_addr(wr_addr),
    .addr(rd_addr), .busy(lk)
  );
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          ok, byp;
    assign a   = rd_addr[i*AW +: AW];
    assign ok  = run & VMASK[a];
    assign byp = wr_en & (wr_addr == a);
    assign rd_data[i*XLEN +: XLEN] = ok ? (byp ? wr_data : rf[a]) : '0;
    // a value arriving on the bypass this cycle counts as ready
    assign rd_busy[i] = ok & lk[i] & ~byp;
  end
endmodule

// File: doc/reg_file_scb.md
# reg_file_scb

Parametrised RISC-V integer register file with a configurable number of combinational read ports, one write port, write-to-read bypass, and a per-register busy scoreboard. After reset it clears the storage array through a sequential sweep, one entry per cycle, so the array can map onto RAM. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; AW = $clog2(NREGS)
- NRD, 2, number of read ports
- ZERO_REG, 1, when 1, register 0 reads as 0, is never written, and is never busy
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i: source register has a pending write
- wr_en  in  1  writeback valid
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- iss_en  in  1  issue valid; marks iss_addr busy
- iss_addr  in  AW  issued destination
- init_done  out  1  high once the clear sweep is complete

## Operation
- States: CLEAR and RUN. Reset enters CLEAR with ptr = 0, all busy bits = 0, and init_done = 0.
- CLEAR:
  - Each cycle writes RF[ptr] = 0 and increments ptr.
  - The cycle that writes ptr = NREGS-1 transitions to RUN.
  - wr_en and iss_en are ignored.
  - rd_data = 0 and rd_busy = 0.
- RUN write: on a rising edge with wr_en = 1, RF[wr_addr] <= wr_data. The write is suppressed when ZERO_REG = 1 and wr_addr = 0, or when wr_addr >= NREGS.
- Read, combinational:
  - If the address is 0 with ZERO_REG = 1, or the address is >= NREGS, rd_data = 0.
  - Otherwise, if wr_en = 1 and wr_addr equals the read address, rd_data = wr_data (bypass).
  - Otherwise, rd_data = RF[addr].
- Scoreboard:
  - busy[iss_addr] is set on iss_en.
  - busy[wr_addr] is cleared on wr_en.
  - iss_en and wr_en to the same address in the same cycle: busy ends set, because the new producer wins.
  - Register 0 (when ZERO_REG = 1) and out-of-range addresses are never set.
- rd_busy[i] = busy[rd_addr_i] & ~(wr_en & wr_addr == rd_addr_i), so the bypassed value counts as ready.
- Reset asserted in any state, mid-sweep included, restarts CLEAR from ptr = 0 and clears all busy bits. Array contents are not preserved.

## Timing
- init_done falls on the first edge with rst_n = 0.
- init_done rises after exactly NREGS rising edges with rst_n = 1: 32 cycles at the defaults.
- Read latency is 0 cycles, combinational from rd_addr, wr_en, wr_addr, and wr_data.
- A write is visible through the bypass in the same cycle, and from the array on the next cycle.
- A busy bit set at edge N is reported by rd_busy from cycle N onward. The bit clears at the edge ending the wr_en cycle, and rd_busy is already low during that wr_en cycle.
- Reset values: init_done = 0, rd_busy = 0, rd_data = 0 while in CLEAR.
- Every read port is independent. Several ports reading the same address return identical data.

## Structure
- Package reg_file_pkg holds:
  - the default XLEN and NREGS
  - the state enum {CLEAR, RUN}
  - the ABI register-index constants: ZERO = 0, RA = 1, SP = 2, …, T6 = 31
- Sub-module reg_file_scoreboard holds the NREGS-bit busy vector:
  - inputs: set and clear port pairs, plus a sync clear
  - outputs: a lookup per read port
- The top level contains the FSM, the clear pointer, the storage array, and the read/bypass muxes.

## Test plan
- Reset sweep: release rst_n, then read all 32 registers each cycle. Required: init_done = 0 for 32 cycles then 1. Every read returns 0 throughout. wr_en pulsed during CLEAR leaves RF unchanged.
- Write/read: write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 the next cycle. Required: both return 0xDEADBEEF. Writing 0x12345678 to x0 leaves x0 reading 0.
- Bypass: in one cycle assert wr_en, wr_addr = 7, wr_data = 0xA5A5A5A5 with rd_addr0 = 7. Required: rd_data0 = 0xA5A5A5A5 in that same cycle, and rd_busy0 = 0 even though x7 was busy.
- Scoreboard: issue x10, then hold rd_addr1 = 10 for 3 cycles. Required: rd_busy1 = 1 for those cycles, 0 during the writeback cycle, and 0 afterwards. Simultaneous iss_en and wr_en on x10 leaves rd_busy = 1.
- Mid-sweep reset: assert rst_n = 0 at ptr = 17, then release. Required: the sweep restarts and init_done rises 32 cycles after release. Busy bits set before reset read 0.
- Parameter sweep: NRD = 3 and NREGS = 16 with ZERO_REG = 0. Required: x0 is writable, init_done arrives after 16 cycles, and all 3 ports read correctly.
